net_bus_merge2: RTL
===================

// Module: net_bus_merge2
// PURPOSE
//  Two-input NetBus merge stage: the receive-side counterpart of the dual-port NetBus transmitter.
//  Accepts two independent NetBus word streams, buffers each in a 2-entry FIFO and merges them
//  word-by-word onto one registered NetBus output using round-robin arbitration.
//  Output feeds any single-port NetBus consumer; a SRC tag identifies the originating port.
// PARAMETERS
//  DATA_WIDTH  4  NetBus lane parameter; word width W = DATA_WIDTH*9+14 (50 bits at default)
// PORTS
//  CLK      in   1  sole clock; both input streams and the output are synchronous to it
//  RST      in   1  asynchronous, active-high reset
//  RDATA0   in   W  port 0 word
//  RVALID0  in   1  port 0 word valid
//  RREADY0  out  1  port 0 ready (registered)
//  RDATA1   in   W  port 1 word
//  RVALID1  in   1  port 1 word valid
//  RREADY1  out  1  port 1 ready (registered)
//  DATA     out  W  merged word (registered)
//  VALID    out  1  merged word valid (registered)
//  READY    in   1  downstream ready
//  SRC      out  1  port index of the word on DATA (0/1), valid when VALID=1
// BEHAVIOUR
//  - Reset (async assert, sync release): VALID=0, DATA=0, SRC=0, both FIFO counts=0, rd/wr ptrs=0,
//    priority PRI=0 (port 0 first); RREADY0=RREADY1=1 during and after reset.
//  - Handshake: transfer on a port when VALID&READY high at a CLK edge. VALID/DATA/SRC hold stable
//    while VALID=1 and READY=0. Inputs obey the same rule; RVALIDn is never required to wait on RREADYn.
//  - Per-port FIFO n: depth 2, count_n in {0,1,2}. RREADYn = (count_n != 2), from flops only
//    (no combinational path from READY or RVALIDn). push_n = RVALIDn & RREADYn.
//  - Output register load enable: LD = ~VALID | READY.
//  - Arbitration when LD: cand_n = (count_n != 0).
//     both cand -> grant PRI; one cand -> grant it; none -> VALID<=0 (DATA/SRC hold).
//     On grant g: DATA<=head_g, SRC<=g, VALID<=1, pop_g, PRI<=~g.
//  - Count update: count_n += push_n - pop_n; push and pop on same edge leaves count unchanged;
//    push at count 2 cannot occur (RREADYn=0). Pointers are 1-bit, wrap 1->0.
//  - Latency: word accepted at edge k into empty FIFO with LD true at k+1 -> VALID=1 after edge k+1.
//  - Throughput: 1 word/cycle total; a single active port sustains 1 word/cycle (count stays 1).
//  - Ordering: per-port order strictly preserved; no word dropped or duplicated under any
//    READY/RVALID pattern.
//  - Capacity under READY=0: 2 words per FIFO + 1 in output register = 5 words max.
//  - RST mid-operation: all buffered words discarded, state as at reset; the first word after
//    release is taken from port 0 if both ports present data.
// TESTING
//  1. Assert RST with both FIFOs full and VALID=1 -> VALID=0, SRC=0, RREADY0=RREADY1=1 immediately
//     (asynchronous); no stale word appears after release.
//  2. Port 0 streams 0x1..0x8 back-to-back, READY=1, port 1 idle -> DATA 0x1..0x8 on consecutive
//     cycles, first VALID 1 cycle after first acceptance, SRC=0 throughout, RREADY0 never low.
//  3. Both ports stream continuously (port 0: 0xA0.., port 1: 0xB0..), READY=1 ->
//     SRC pattern 0,1,0,1..., starting with port 0; each port's sequence in order.
//  4. READY=0 while both ports push -> exactly 5 words accepted, then RREADY0=RREADY1=0;
//     raise READY -> all 5 delivered, no loss or duplicate, RREADYn rise 1 cycle after their pops.
//  5. Port 1 alone sends 0xB0 (PRI becomes 0), then both present words same cycle ->
//     port 0 granted next, then port 1.
//  6. Random RVALID0/RVALID1/READY (10k cycles) -> scoreboard per port: order preserved,
//     output stable while stalled, count never exceeds 2.

Source files
------------

// File: rtl/net_bus_merge2.sv
// Two-input NetBus merge: each input word stream is buffered in a 2-deep FIFO, then the two
// streams are merged round-robin onto one registered output with a source tag.
module net_bus_merge2 #(
  parameter  int DATA_WIDTH = 4,
  localparam int W          = DATA_WIDTH * 9 + 14
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [W-1:0] RDATA0,
  input  logic         RVALID0,
  output logic         RREADY0,
  input  logic [W-1:0] RDATA1,
  input  logic         RVALID1,
  output logic         RREADY1,
  output logic [W-1:0] DATA,
  output logic         VALID,
  input  logic         READY,
  output logic         SRC
);

  logic [1:0]   rvalid;
  logic [1:0]   rready;
  logic [1:0]   push;
  logic [1:0]   pop;
  logic [1:0]   cand;
  logic [W-1:0] rdata [2];
  logic [W-1:0] head  [2];

  logic ld;
  logic gnt_vld;
  logic gnt;
  logic pri;

  assign rvalid   = {RVALID1, RVALID0};
  assign rdata[0] = RDATA0;
  assign rdata[1] = RDATA1;
  assign RREADY0  = rready[0];
  assign RREADY1  = rready[1];

  for (genvar n = 0; n < 2; n++) begin : g_fifo
    logic [W-1:0] mem [2];
    logic [1:0]   cnt;
    logic [1:0]   cnt_nxt;
    logic         wp;
    logic         rp;
    logic         rdy;

    assign push[n]   = rvalid[n] & rdy;
    assign cand[n]   = (cnt != 2'd0);
    assign head[n]   = mem[rp];
    assign rready[n] = rdy;

    always_comb begin
      cnt_nxt = cnt;
      if (push[n] && !pop[n])
        cnt_nxt = cnt + 2'd1;
      else if (!push[n] && pop[n])
        cnt_nxt = cnt - 2'd1;
    end

    // Ready is registered from the next count so it never depends on READY/RVALID combinationally.
    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        cnt <= 2'd0;
        wp  <= 1'b0;
        rp  <= 1'b0;
        rdy <= 1'b1;
      end else begin
        cnt <= cnt_nxt;
        rdy <= (cnt_nxt != 2'd2);
        if (push[n]) wp <= ~wp;
        if (pop[n])  rp <= ~rp;
      end
    end

    always_ff @(posedge CLK) begin
      if (push[n]) mem[wp] <= rdata[n];
    end
  end

  assign ld = ~VALID | READY;

  always_comb begin
    gnt_vld = 1'b0;
    gnt     = 1'b0;
    if (cand[0] && cand[1]) begin
      gnt_vld = 1'b1;
      gnt     = pri;
    end else if (cand[0]) begin
      gnt_vld = 1'b1;
      gnt     = 1'b0;
    end else if (cand[1]) begin
      gnt_vld = 1'b1;
      gnt     = 1'b1;
    end
  end

  assign pop = (ld && gnt_vld) ? (gnt ? 2'b10 : 2'b01) : 2'b00;

  // Output register: loads whenever empty or being consumed; priority flips away from the winner.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      VALID <= 1'b0;
      DATA  <= '0;
      SRC   <= 1'b0;
      pri   <= 1'b0;
    end else if (ld) begin
      if (gnt_vld) begin
        VALID <= 1'b1;
        DATA  <= head[gnt];
        SRC   <= gnt;
        pri   <= ~gnt;
      end else begin
        VALID <= 1'b0;
      end
    end
  end

endmodule
